// File: rtl/canvas_port_arbiter_pkg.sv
// canvas_port_arbiter_pkg: canvas geometry and arbiter state encoding
// shared by the canvas port arbiter, mouse writer and recognizer.
package canvas_port_arbiter_pkg;

   localparam int CANVAS_ADDR_W = 10;
   localparam int CANVAS_SIZE   = 1 << CANVAS_ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_CLEAR = 2'd2
   } arb_state_t;

endpackage

// File: rtl/canvas_wr_fifo.sv
// canvas_wr_fifo: small synchronous FIFO holding {addr, pixel} mouse
// writes while the canvas port is owned by another user.
module canvas_wr_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wp;
   logic [AW:0]      rp;
   logic [WIDTH-1:0] mem [DEPTH];

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) &&
                  (wp[AW-1:0] == rp[AW-1:0]);
   assign head  = mem[rp[AW-1:0]];

   // pointer update; flush empties the FIFO and wins over push/pop
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push && !full)
            wp <= wp + (AW+1)'(1);
         if (pop && !empty)
            rp <= rp + (AW+1)'(1);
      end
   end

   // entry storage, written only on an accepted push
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wp[AW-1:0]] <= din;
   end

endmodule

// File: rtl/canvas_port_arbiter.sv
// canvas_port_arbiter: owns canvas RAM port A and shares it between
// buffered mouse writes, recognizer read bursts and a zeroing sweep.
module canvas_port_arbiter
   import canvas_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = CANVAS_ADDR_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_data,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic              rd_data,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              wr_overflow,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_d,
   output logic              mem_we,
   input  logic              mem_spo
);

   arb_state_t        state;
   logic              clear_pending;
   logic [ADDR_W-1:0] sweep;
   logic              done_q;
   logic              ovf_q;

   logic [ADDR_W:0]   fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              flush;
   logic              push;
   logic              pop;

   // a new clear discards buffered pixels; pixels during a clear are stale
   assign flush = clear_start && !clear_pending;
   assign push  = wr_en && !clear_pending && !flush &&
                  (state != ST_CLEAR);
   // drain only when no clear or read is asking for the port
   assign pop   = (state == ST_IDLE) && !clear_pending &&
                  !clear_start && !rd_req && !fifo_empty;

   canvas_wr_fifo #(
      .WIDTH (ADDR_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   ({wr_addr, wr_data}),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // arbiter FSM with clear request latch, sweep counter and flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         clear_pending <= 1'b0;
         sweep         <= '0;
         done_q        <= 1'b0;
         ovf_q         <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (push && fifo_full)
            ovf_q <= 1'b1;
         unique case (state)
            ST_IDLE: begin
               if (clear_pending) begin
                  state         <= ST_CLEAR;
                  sweep         <= '0;
                  clear_pending <= 1'b0;
               end else if (rd_req && !clear_start) begin
                  state <= ST_READ;
               end
            end
            ST_READ: begin
               if (!rd_req)
                  state <= ST_IDLE;
            end
            ST_CLEAR: begin
               sweep <= sweep + ADDR_W'(1);
               if (&sweep) begin
                  state  <= ST_IDLE;
                  done_q <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (clear_start)
            clear_pending <= 1'b1;
      end
   end

   // port A decode from registered state, FIFO head and read address
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_d    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (pop) begin
               mem_we   = 1'b1;
               mem_addr = fifo_head[ADDR_W:1];
               mem_d    = fifo_head[0];
            end
         end
         ST_READ: begin
            mem_addr = rd_addr;
         end
         ST_CLEAR: begin
            mem_we   = 1'b1;
            mem_addr = sweep;
         end
         default: ;
      endcase
   end

   assign rd_gnt      = (state == ST_READ);
   assign rd_data     = mem_spo;
   assign clear_busy  = clear_pending || (state == ST_CLEAR);
   assign clear_done  = done_q;
   assign wr_overflow = ovf_q;

endmodule

// File: tb/tb_canvas_port_arbiter.sv
// tb_canvas_port_arbiter: scenario tasks plus random traffic, checked
// against a queue-based reference model and a behavioural canvas RAM.
module tb_canvas_port_arbiter;
   import canvas_port_arbiter_pkg::*;

   localparam int AW    = CANVAS_ADDR_W;
   localparam int SIZE  = CANVAS_SIZE;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic          wr_data = 1'b0;
   logic          rd_req = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          clear_start = 1'b0;
   logic          rd_gnt, rd_data, clear_busy, clear_done;
   logic          wr_overflow, mem_d, mem_we, mem_spo;
   logic [AW-1:0] mem_addr;

   bit ram [SIZE];
   int total = 0;
   int bad = 0;

   // reference model state
   int            m_mode = 0;
   logic [AW:0]   m_q[$];
   bit            m_pend = 0;
   int            m_sweep = 0;
   bit            m_done = 0;
   bit            m_ovf = 0;
   bit            m_canvas [SIZE];

   always #5 clk = ~clk;

   // behavioural canvas RAM: async read, write on clock edge
   assign mem_spo = ram[mem_addr];
   always @(posedge clk) if (mem_we === 1'b1) ram[mem_addr] <= mem_d;

   canvas_port_arbiter #(
      .ADDR_W     (AW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_gnt      (rd_gnt),
      .rd_data     (rd_data),
      .clear_start (clear_start),
      .clear_busy  (clear_busy),
      .clear_done  (clear_done),
      .wr_overflow (wr_overflow),
      .mem_addr    (mem_addr),
      .mem_d       (mem_d),
      .mem_we      (mem_we),
      .mem_spo     (mem_spo)
   );

   // {gnt, rdata, busy, done, ovf, we, addr, d}
   function automatic logic [16:0] dut_vec();
      return {rd_gnt, rd_gnt & rd_data, clear_busy, clear_done,
              wr_overflow, mem_we, mem_addr, mem_d};
   endfunction

   function automatic logic [16:0] exp_vec();
      logic g, w, d;
      logic [AW-1:0] a;
      g = 1'b0; w = 1'b0; d = 1'b0; a = '0;
      if (m_mode == 1) begin
         g = 1'b1; a = rd_addr;
      end else if (m_mode == 2) begin
         w = 1'b1; a = 10'(m_sweep);
      end else if (!m_pend && !clear_start && !rd_req
                   && m_q.size() > 0) begin
         w = 1'b1; a = m_q[0][AW:1]; d = m_q[0][0];
      end
      return {g, g & m_canvas[rd_addr], m_pend || m_mode == 2,
              m_done, m_ovf, w, a, d};
   endfunction

   task automatic model_step();
      logic [16:0] e;
      bit do_pop;
      e = exp_vec();
      if (e[11]) m_canvas[e[10:1]] = e[0];
      if (!rst_n) begin
         m_mode = 0; m_q.delete(); m_pend = 0;
         m_sweep = 0; m_done = 0; m_ovf = 0;
         return;
      end
      do_pop = (m_mode == 0) && e[11];
      m_done = 0;
      if (clear_start) m_q.delete();
      else begin
         if (wr_en && !m_pend && m_mode != 2) begin
            if (m_q.size() == DEPTH) m_ovf = 1;
            else m_q.push_back({wr_addr, wr_data});
         end
         if (do_pop) void'(m_q.pop_front());
      end
      case (m_mode)
         0: if (m_pend) begin
               m_mode = 2; m_sweep = 0; m_pend = 0;
            end else if (rd_req && !clear_start) m_mode = 1;
         1: if (!rd_req) m_mode = 0;
         default:
            if (m_sweep == SIZE - 1) begin
               m_mode = 0; m_done = 1; m_sweep = 0;
            end else m_sweep++;
      endcase
      if (clear_start) m_pend = 1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic quiet();
      wr_en = 0; wr_addr = '0; wr_data = 0;
      rd_req = 0; rd_addr = '0; clear_start = 0;
   endtask

   task automatic do_reset();
      quiet(); rst_n = 0; tick(); tick(); rst_n = 1;
   endtask

   task automatic test_reset();
      logic [16:0] got;
      quiet(); rst_n = 0;
      wr_en = 1; wr_addr = 10'h3ff; rd_req = 1; clear_start = 1;
      tick(); tick();
      quiet(); rst_n = 1; #1;
      got = dut_vec(); total++;
      if (got !== 17'd0) begin
         bad++; $display("FAIL reset got=%h exp=0", got);
      end
      total++;
      if (got !== exp_vec()) begin
         bad++; $display("FAIL reset_model got=%h exp=%h", got, exp_vec());
      end
   endtask

   task automatic test_single_write();
      wr_en = 1; wr_addr = 10'h123; wr_data = 1; #1;
      total++;
      if (mem_we !== 1'b0) begin
         bad++; $display("FAIL sw_early we=%b exp=0", mem_we);
      end
      tick(); quiet(); #1;
      total++;
      if (mem_we !== 1'b1 || mem_addr !== 10'h123 || mem_d !== 1'b1) begin
         bad++;
         $display("FAIL sw_write we=%b a=%h d=%b exp 1/123/1",
                  mem_we, mem_addr, mem_d);
      end
      total++;
      if (dut_vec() !== exp_vec()) begin
         bad++; $display("FAIL sw_model got=%h exp=%h", dut_vec(), exp_vec());
      end
      tick(); #1;
      total++;
      if (mem_we !== 1'b0) begin
         bad++; $display("FAIL sw_empty we=%b exp=0", mem_we);
      end
      tick();
   endtask

   task automatic test_read_burst();
      int slot [6];
      logic [AW:0] rec[$];
      for (int j = 0; j < 6; j++)
         slot[j] = 30 + j * 160 + int'($urandom_range(0, 100));
      rd_req = 1;
      for (int i = 0; i < SIZE; i++) begin
         rd_addr = 10'(i); wr_en = 0;
         for (int j = 0; j < 6; j++) if (slot[j] == i) begin
            wr_en = 1; wr_addr = 10'($urandom); wr_data = 1'($urandom);
            if (j < 4) rec.push_back({wr_addr, wr_data});
         end
         #1; total++;
         if (dut_vec() !== exp_vec()) begin
            bad++;
            if (bad < 20) $display("FAIL burst c=%0d got=%h exp=%h",
                                   i, dut_vec(), exp_vec());
         end
         total++;
         if (rd_gnt === 1'b1 && mem_we === 1'b1) begin
            bad++; $display("FAIL burst_mutex c=%0d gnt=1 we=1", i);
         end
         if (i == 'h123) begin
            total++;
            if (rd_data !== 1'b1) begin
               bad++; $display("FAIL burst_rd123 got=%b exp=1", rd_data);
            end
         end
         tick();
      end
      wr_en = 0; total++;
      if (wr_overflow !== 1'b1) begin
         bad++; $display("FAIL burst_ovf got=%b exp=1", wr_overflow);
      end
      rd_req = 0; #1; total++;
      if (mem_we !== 1'b0 || rd_gnt !== 1'b1) begin
         bad++; $display("FAIL burst_drop we=%b gnt=%b exp 0/1", mem_we, rd_gnt);
      end
      tick();
      for (int k = 0; k < 4; k++) begin
         #1; total++;
         if (mem_we !== 1'b1 || {mem_addr, mem_d} !== rec[k]) begin
            bad++;
            $display("FAIL drain%0d we=%b ad=%h exp=%h",
                     k, mem_we, {mem_addr, mem_d}, rec[k]);
         end
         tick();
      end
      #1; total++;
      if (mem_we !== 1'b0) begin
         bad++; $display("FAIL drain_end we=%b exp=0", mem_we);
      end
   endtask

   task automatic test_clear_idle();
      int exp_a;
      bit seen;
      do_reset(); rd_req = 1; tick();
      for (int k = 0; k < 3; k++) begin
         wr_en = 1; wr_addr = 10'($urandom); wr_data = 1; tick();
      end
      wr_en = 0; rd_req = 0; tick();
      clear_start = 1; #1; total++;
      if (mem_we !== 1'b0 || dut_vec() !== exp_vec()) begin
         bad++; $display("FAIL clr_start got=%h exp=%h", dut_vec(), exp_vec());
      end
      tick(); clear_start = 0;
      exp_a = 0; seen = 0;
      for (int c = 0; c < 1100 && !seen; c++) begin
         #1; total++;
         if (dut_vec() !== exp_vec()) begin
            bad++;
            if (bad < 20) $display("FAIL clr c=%0d got=%h exp=%h",
                                   c, dut_vec(), exp_vec());
         end
         if (mem_we === 1'b1) begin
            total++;
            if (mem_addr !== 10'(exp_a) || mem_d !== 1'b0) begin
               bad++;
               if (bad < 20) $display("FAIL clr_addr got=%h exp=%h",
                                      mem_addr, 10'(exp_a));
            end
            exp_a++;
         end
         if (clear_done === 1'b1) begin
            seen = 1; total++;
            if (clear_busy !== 1'b0 || exp_a != SIZE) begin
               bad++;
               $display("FAIL clr_done busy=%b writes=%0d exp 0/%0d",
                        clear_busy, exp_a, SIZE);
            end
         end
         tick();
      end
      total++;
      if (!seen) begin
         bad++; $display("FAIL clr_timeout done=0 exp=1");
      end
      #1; total++;
      if (mem_we !== 1'b0 || clear_done !== 1'b0) begin
         bad++; $display("FAIL clr_after we=%b done=%b exp 0/0",
                         mem_we, clear_done);
      end
   endtask

   task automatic test_clear_during_read();
      bit first, seen;
      do_reset(); rd_req = 1;
      for (int c = 0; c < 40; c++) begin
         wr_en = (c == 5 || c == 8); wr_addr = 10'($urandom); wr_data = 1;
         clear_start = (c == 12);
         #1; total++;
         if (dut_vec() !== exp_vec() || mem_we !== 1'b0) begin
            bad++; $display("FAIL cdr c=%0d got=%h exp=%h",
                            c, dut_vec(), exp_vec());
         end
         if (c == 13) begin
            total++;
            if (clear_busy !== 1'b1 || rd_gnt !== 1'b1) begin
               bad++; $display("FAIL cdr_busy busy=%b gnt=%b exp 1/1",
                               clear_busy, rd_gnt);
            end
         end
         tick();
      end
      wr_en = 0; clear_start = 0; rd_req = 0;
      first = 1; seen = 0;
      for (int c = 0; c < 1100 && !seen; c++) begin
         wr_en = 1'($urandom); wr_addr = 10'($urandom); wr_data = 1;
         #1; total++;
         if (dut_vec() !== exp_vec()) begin
            bad++;
            if (bad < 20) $display("FAIL cdr_sw c=%0d got=%h exp=%h",
                                   c, dut_vec(), exp_vec());
         end
         if (mem_we === 1'b1 && first) begin
            first = 0; total++;
            if (mem_addr !== 10'd0 || mem_d !== 1'b0) begin
               bad++; $display("FAIL cdr_first a=%h d=%b exp 0/0",
                               mem_addr, mem_d);
            end
         end
         if (clear_done === 1'b1) seen = 1;
         tick();
      end
      wr_en = 0; total++;
      if (!seen || wr_overflow !== 1'b0) begin
         bad++; $display("FAIL cdr_end done=%b ovf=%b exp 1/0",
                         seen, wr_overflow);
      end
      tick(); tick();
   endtask

   task automatic test_reset_mid_sweep();
      bit hit;
      quiet(); tick(); clear_start = 1; tick(); clear_start = 0;
      hit = 0;
      for (int c = 0; c < 1100 && !hit; c++) begin
         #1; total++;
         if (dut_vec() !== exp_vec()) begin
            bad++;
            if (bad < 20) $display("FAIL rms c=%0d got=%h exp=%h",
                                   c, dut_vec(), exp_vec());
         end
         if (m_mode == 2 && m_sweep == 500) hit = 1;
         else tick();
      end
      total++;
      if (!hit || mem_addr !== 10'd500) begin
         bad++; $display("FAIL rms_reach a=%h exp=1f4", mem_addr);
      end
      rst_n = 0; tick(); rst_n = 1; #1; total++;
      if (dut_vec() !== 17'd0) begin
         bad++; $display("FAIL rms_reset got=%h exp=0", dut_vec());
      end
      wr_en = 1; wr_addr = 10'h2a5; wr_data = 1; tick(); wr_en = 0; #1;
      total++;
      if (mem_we !== 1'b1 || mem_addr !== 10'h2a5 || mem_d !== 1'b1) begin
         bad++; $display("FAIL rms_wr we=%b a=%h d=%b exp 1/2a5/1",
                         mem_we, mem_addr, mem_d);
      end
      tick();
   endtask

   task automatic test_clear_vs_read();
      int done_c, gnt_c;
      quiet(); tick(); tick();
      clear_start = 1; rd_req = 1; #1; total++;
      if (dut_vec() !== exp_vec()) begin
         bad++; $display("FAIL cvr_start got=%h exp=%h", dut_vec(), exp_vec());
      end
      tick(); clear_start = 0;
      done_c = -1; gnt_c = -1;
      for (int c = 0; c < 1100 && gnt_c < 0; c++) begin
         #1; total++;
         if (dut_vec() !== exp_vec()) begin
            bad++;
            if (bad < 20) $display("FAIL cvr c=%0d got=%h exp=%h",
                                   c, dut_vec(), exp_vec());
         end
         if (clear_done === 1'b1) done_c = c;
         if (rd_gnt === 1'b1) gnt_c = c;
         tick();
      end
      total++;
      if (done_c < 0 || gnt_c != done_c + 1) begin
         bad++; $display("FAIL cvr_order gnt_c=%0d exp=%0d", gnt_c, done_c + 1);
      end
      rd_req = 0; tick(); tick();
   endtask

   task automatic test_random();
      bit r;
      quiet(); r = 0;
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 799) != 0);
         if ($urandom_range(0, 24) == 0) r = ~r;
         rd_req = r; rd_addr = 10'($urandom);
         wr_en = ($urandom_range(0, 2) == 0);
         wr_addr = 10'($urandom); wr_data = 1'($urandom);
         clear_start = ($urandom_range(0, 399) == 0);
         #1; total++;
         if (dut_vec() !== exp_vec()) begin
            bad++;
            if (bad < 20) $display("FAIL rand c=%0d got=%h exp=%h",
                                   c, dut_vec(), exp_vec());
         end
         total++;
         if (rd_gnt === 1'b1 && mem_we === 1'b1) begin
            bad++; $display("FAIL rand_mutex c=%0d gnt=1 we=1", c);
         end
         tick();
      end
      rst_n = 1; quiet();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_burst();
      test_clear_idle();
      test_clear_during_read();
      test_reset_mid_sweep();
      test_clear_vs_read();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
